// File: rtl/dsp_vu_meter.sv
// Level-meter ballistics: converts a per-frame RMS amplitude into a
// 6 dB/segment thermometer bar with instant attack / timed decay and a
// peak-hold marker. One result per accepted frame strobe; strobes that
// arrive while a frame is in flight are dropped and flagged.
module dsp_vu_meter #(
  parameter int LEVELS    = 16,
  parameter int HOLD      = 48,
  parameter int DECAY_DIV = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [15:0]       iLevel,
  input  logic              iStrobe,
  output logic [LEVELS-1:0] oBar,
  output logic [LEVELS-1:0] oPeak,
  output logic [4:0]        oSeg,
  output logic              oValid,
  output logic              oBusy,
  output logic              oDrop
);

  // dcnt must reach DECAY_DIV-1, hcnt must reach HOLD, neither may wrap
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, OUT} state_t;

  state_t            state_q, state_d;
  logic [15:0]       lvl_q, lvl_d;
  logic [3:0]        idx_q, idx_d;
  logic [4:0]        seg_q, seg_d;
  logic [4:0]        bar_q, bar_d;
  logic [4:0]        peak_q, peak_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [LEVELS-1:0] obar_q, obar_d;
  logic [LEVELS-1:0] opeak_q, opeak_d;
  logic [4:0]        oseg_q, oseg_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;

  logic              busy;
  logic [4:0]        seg_c;

  // The oValid cycle still counts as busy so a strobe landing on it is dropped
  assign busy  = (state_q != IDLE) || valid_q;
  assign seg_c = (seg_q > 5'(LEVELS)) ? 5'(LEVELS) : seg_q;

  // State and datapath registers; reset mid-frame simply abandons the frame
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      bar_q   <= '0;
      peak_q  <= '0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      obar_q  <= '0;
      opeak_q <= '0;
      oseg_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      bar_q   <= bar_d;
      peak_q  <= peak_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      obar_q  <= obar_d;
      opeak_q <= opeak_d;
      oseg_q  <= oseg_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: MSB-first scan for the leading one, then ballistics, then output
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    bar_d   = bar_q;
    peak_d  = peak_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    obar_d  = obar_q;
    opeak_d = opeak_q;
    oseg_d  = oseg_q;
    valid_d = 1'b0;
    drop_d  = iStrobe && busy;

    case (state_q)
      IDLE: begin
        if (iStrobe && !busy) begin
          lvl_d   = iLevel;
          idx_d   = '0;
          seg_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // first set bit from the top fixes seg = floor(log2(lvl)) + 1
        if (seg_q == 5'd0 && lvl_q[4'd15 - idx_q])
          seg_d = 5'd16 - {1'b0, idx_q};
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15)
          state_d = UPDATE;
      end
      UPDATE: begin
        // bar: instant attack, one segment down every DECAY_DIV quiet frames
        if (seg_c >= bar_q) begin
          bar_d  = seg_c;
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DECAY_DIV - 1)) begin
          bar_d  = bar_q - 5'd1;   // bar_q > seg_c >= 0, so no underflow
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
        // peak: hold for HOLD frames, then fall toward the new bar
        if (seg_c >= peak_q) begin
          peak_d = seg_c;
          hcnt_d = HW'(HOLD);
        end else if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - HW'(1);
        end else if (peak_q > bar_d) begin
          peak_d = peak_q - 5'd1;
        end
        state_d = OUT;
      end
      OUT: begin
        for (int k = 0; k < LEVELS; k++) begin
          obar_d[k]  = (5'(k) < bar_q);
          opeak_d[k] = (5'(k + 1) == peak_q);
        end
        oseg_d  = seg_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oBar   = obar_q;
  assign oPeak  = opeak_q;
  assign oSeg   = oseg_q;
  assign oValid = valid_q;
  assign oBusy  = busy;
  assign oDrop  = drop_q;

endmodule

// File: tb/tb_dsp_vu_meter.sv
// Self-checking bench for dsp_vu_meter: table of frames with hand-derived
// results, a small ballistics model for long sequences, and a scoreboard
// queue popped whenever the DUT pulses oValid.
module tb_dsp_vu_meter;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iLevel = '0;
  logic        iStrobe = 1'b0;
  logic [15:0] oBar, oPeak;
  logic [4:0]  oSeg;
  logic        oValid, oBusy, oDrop;

  dsp_vu_meter #(.LEVELS(16), .HOLD(48), .DECAY_DIV(4)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLevel(iLevel), .iStrobe(iStrobe),
    .oBar(oBar), .oPeak(oPeak), .oSeg(oSeg),
    .oValid(oValid), .oBusy(oBusy), .oDrop(oDrop)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          seg;
    logic [15:0] bar;
    logic [15:0] peak;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] lvl;
    int          seg;
    logic [15:0] bar;
    logic [15:0] peak;
  } vec_t;

  exp_t sb[$];
  vec_t vec[8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_drop  = 0;

  // reference ballistics state
  int mbar, mpeak, mdcnt, mhcnt;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge iCLK) cyc <= cyc + 1;

  // scoreboard side: compare every oValid against the oldest expectation
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oDrop) n_drop++;
      if (oValid) begin
        n_valid++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("seg", oSeg, e.seg);
          chk("bar", oBar, e.bar);
          chk("peak", oPeak, e.peak);
          chk("latency", cyc, e.cyc);
          chk("busy_in_valid", oBusy, 1);
        end
      end
    end
  end

  function automatic logic [15:0] therm(input int n);
    int v;
    v = (1 << n) - 1;
    return v[15:0];
  endfunction

  function automatic logic [15:0] onehot(input int n);
    int v;
    v = (n == 0) ? 0 : (1 << (n - 1));
    return v[15:0];
  endfunction

  task automatic model_reset();
    mbar = 0; mpeak = 0; mdcnt = 0; mhcnt = 0;
  endtask

  // drive one strobe after a posedge; push the expected record if given
  task automatic strobe(input logic [15:0] lv, input bit push, input exp_t e);
    @(posedge iCLK); #1;
    iLevel  = lv;
    iStrobe = 1'b1;
    if (push) begin
      e.cyc = cyc + 19;
      sb.push_back(e);
    end
    @(posedge iCLK); #1;
    iStrobe = 1'b0;
    iLevel  = 16'hDEAD;   // iLevel must not be sampled outside the strobe
  endtask

  task automatic model_frame(input logic [15:0] lv);
    int s;
    exp_t e;
    s = 0;
    for (int b = 0; b < 16; b++) if (lv[b]) s = b + 1;
    if (s >= mbar) begin mbar = s; mdcnt = 0; end
    else if (mdcnt == 3) begin mbar = mbar - 1; mdcnt = 0; end
    else mdcnt = mdcnt + 1;
    if (s >= mpeak) begin mpeak = s; mhcnt = 48; end
    else if (mhcnt > 0) mhcnt = mhcnt - 1;
    else if (mpeak > mbar) mpeak = mpeak - 1;
    e.seg = s; e.bar = therm(mbar); e.peak = onehot(mpeak); e.cyc = 0;
    strobe(lv, 1'b1, e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge iCLK); #2;
    iRST_N = 1'b0;
    wait_cycles(2);
    sb.delete();
    model_reset();
    iRST_N = 1'b1;
  endtask

  initial begin
    exp_t dummy;
    int v0, d0;
    dummy = '{0, 16'h0, 16'h0, 0};
    vec[0] = '{16'h0100,  9, 16'h01FF, 16'h0100};
    vec[1] = '{16'h0001,  1, 16'h01FF, 16'h0100};
    vec[2] = '{16'h0000,  0, 16'h01FF, 16'h0100};
    vec[3] = '{16'h0003,  2, 16'h01FF, 16'h0100};
    vec[4] = '{16'h0000,  0, 16'h00FF, 16'h0100};
    vec[5] = '{16'hFFFF, 16, 16'hFFFF, 16'h8000};
    vec[6] = '{16'h0400, 11, 16'hFFFF, 16'h8000};
    vec[7] = '{16'h7FFF, 15, 16'hFFFF, 16'h8000};
    model_reset();

    // reset held with strobes toggling: everything stays zero
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK); #1;
      iStrobe = ~iStrobe;
      iLevel  = 16'hFFFF;
      @(negedge iCLK);
      chk("reset_outs", {oBar, oPeak, oSeg, oValid, oBusy, oDrop}, 0);
    end
    iStrobe = 1'b0;
    chk("reset_no_valid", n_valid, 0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;

    // zero input straight from reset
    strobe(16'h0000, 1'b1, '{0, 16'h0, 16'h0, 0});
    wait_cycles(22);
    chk("zero_frame_done", sb.size(), 0);

    // table of frames from a freshly reset state
    do_reset();
    foreach (vec[i]) begin
      strobe(vec[i].lvl, 1'b1, '{vec[i].seg, vec[i].bar, vec[i].peak, 0});
      wait_cycles(22);
      chk("table_frame_done", sb.size(), 0);
    end

    // full scale then a long run of silence, 100 cycles apart
    do_reset();
    model_frame(16'h8000);
    wait_cycles(98);
    chk("fs_bar", oBar, 16'hFFFF);
    chk("fs_peak", oPeak, 16'h8000);
    for (int i = 1; i <= 60; i++) begin
      model_frame(16'h0000);
      wait_cycles(98);
      if (i == 4)  chk("silence4_bar", oBar, 16'h7FFF);
      if (i == 8)  chk("silence8_bar", oBar, 16'h3FFF);
      if (i == 48) chk("silence48_peak", oPeak, 16'h8000);
      if (i == 49) chk("silence49_peak", oPeak, 16'h4000);
    end
    chk("silence_done", sb.size(), 0);

    // collision: second strobe 5 cycles into the first frame is dropped
    do_reset();
    v0 = n_valid; d0 = n_drop;
    model_frame(16'h0020);                 // seg 6
    wait_cycles(3);
    strobe(16'hFFFF, 1'b0, dummy);
    wait_cycles(22);
    chk("collision_drops", n_drop - d0, 1);
    chk("collision_valids", n_valid - v0, 1);

    // strobe on the oValid cycle is dropped, the very next one is accepted
    v0 = n_valid; d0 = n_drop;
    model_frame(16'h0200);                 // seg 10
    begin
      int k;
      k = 0;
      while (!oValid && k < 40) begin
        @(posedge iCLK); #1;
        k++;
      end
      chk("valid_seen", oValid, 1);
    end
    iStrobe = 1'b1; iLevel = 16'h0001;     // lands on the oValid cycle
    @(posedge iCLK); #1;
    iStrobe = 1'b0;
    model_frame(16'h0004);                 // first IDLE cycle after oValid
    wait_cycles(22);
    chk("validcycle_drops", n_drop - d0, 1);
    chk("validcycle_valids", n_valid - v0, 2);

    // reset 8 cycles into a frame: abandoned, then a clean frame follows
    do_reset();
    v0 = n_valid;
    strobe(16'h1000, 1'b0, dummy);
    wait_cycles(7);
    iRST_N = 1'b0;
    #1;
    chk("midscan_rst_outs", {oBar, oPeak, oSeg, oValid, oBusy}, 0);
    wait_cycles(2);
    iRST_N = 1'b1;
    wait_cycles(25);
    chk("midscan_no_valid", n_valid - v0, 0);
    model_reset();
    model_frame(16'h1000);                 // seg 13
    wait_cycles(22);
    chk("post_rst_done", sb.size(), 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
